// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types and constants for the keyboard event controller
//
// Purpose : event record, set-2 prefix byte values and fetch FSM states used
//           by kbd_evt_ctrl and kbd_evt_fifo.
// Ports   : none (package).
package kbd_pkg;

   localparam int KBD_CODE_W = 8;

   localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
   localparam logic [7:0] KBD_PFX_BRK = 8'hF0;

   typedef struct packed {
      logic                  ext;
      logic                  brk;
      logic [KBD_CODE_W-1:0] code;
   } kbd_evt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      WAIT = 2'd2
   } kbd_fetch_e;

endpackage

// File: rtl/kbd_evt_fifo.sv
// rtl/kbd_evt_fifo.sv - first-word-fall-through FIFO of key events
//
// Purpose : holds decoded key events until the CPU reads them; the head entry
//           is always presented on rd_data.
// Ports   : clk, clrn (async active-low reset)
//           push, wr_data     - write request and event to store
//           pop               - read request (ignored while empty)
//           rd_data           - head event (undefined while empty)
//           count             - occupancy, 0..DEPTH
//           full, empty       - occupancy flags
// A push while full succeeds only if a pop happens in the same cycle.
module kbd_evt_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     clrn,
   input  logic                     push,
   input  kbd_evt_t                 wr_data,
   input  logic                     pop,
   output kbd_evt_t                 rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   kbd_evt_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop_ok  = pop & ~empty;
   // a slot freed by a same-cycle pop makes room for the push
   assign push_ok = push & (~full | pop_ok);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // pointers wrap naturally because DEPTH is a power of two
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/kbd_evt_ctrl.sv
// rtl/kbd_evt_ctrl.sv - drains ps2_kbd scan codes into a queue of key events
//
// Purpose : pops raw set-2 bytes from ps2_kbd, folds E0/F0 prefixes into one
//           event per key action and queues events for the CPU.
// Ports   : clk, clrn (async active-low reset)
//           kb_data, kb_ready, kb_rdn - ps2_kbd byte handshake (kb_rdn active low)
//           evt_valid, evt_code, evt_break, evt_ext - head event
//           evt_rd    - CPU pop strobe
//           evt_count - FIFO occupancy
//           overflow, ovf_clr - sticky drop flag and its clear
// Option  : KBD_TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module kbd_evt_ctrl
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CODE_W     = 8
) (
   input  logic                          clk,
   input  logic                          clrn,
   input  logic [CODE_W-1:0]             kb_data,
   input  logic                          kb_ready,
   output logic                          kb_rdn,
   output logic                          evt_valid,
   output logic [CODE_W-1:0]             evt_code,
   output logic                          evt_break,
   output logic                          evt_ext,
   input  logic                          evt_rd,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   input  logic                          ovf_clr
);

   kbd_fetch_e state, state_nxt;
   logic       pend_ext, pend_break;
   logic       byte_take, is_ext, is_brk, byte_evt;
   logic       suppress, push_req, rd_fire, drop;
   logic       fifo_full, fifo_empty;
   kbd_evt_t   new_evt, head_evt;

   // ---------------- fetch FSM ----------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      kb_rdn    = 1'b1;
      unique case (state)
         IDLE: if (kb_ready) state_nxt = POP;
         POP: begin
            kb_rdn    = 1'b0;
            state_nxt = WAIT;
         end
         // ps2_kbd is still moving its read pointer; kb_ready is stale here
         WAIT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- decode ----------------
   assign byte_take = (state == POP);
   assign is_ext    = (kb_data == CODE_W'(KBD_PFX_EXT));
   assign is_brk    = (kb_data == CODE_W'(KBD_PFX_BRK));
   assign byte_evt  = byte_take & ~is_ext & ~is_brk;

   always_comb begin
      new_evt.ext  = pend_ext;
      new_evt.brk  = pend_break;
      new_evt.code = KBD_CODE_W'(kb_data);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pend_ext   <= 1'b0;
         pend_break <= 1'b0;
      end else if (byte_take) begin
         if (is_ext) begin
            pend_ext <= 1'b1;
         end else if (is_brk) begin
            pend_break <= 1'b1;
         end else begin
            pend_ext   <= 1'b0;
            pend_break <= 1'b0;
         end
      end
   end

`ifdef KBD_TYPEMATIC_FILTER_EN
   logic                  held_valid;
   logic                  held_ext;
   logic [KBD_CODE_W-1:0] held_code;
   logic                  held_match;

   assign held_match = held_valid & (held_ext == new_evt.ext) & (held_code == new_evt.code);
   // typematic repeats of the key still held down never reach the FIFO
   assign suppress   = held_match & ~new_evt.brk;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         held_valid <= 1'b0;
         held_ext   <= 1'b0;
         held_code  <= '0;
      end else if (byte_evt) begin
         if (!new_evt.brk && !held_match) begin
            held_valid <= 1'b1;
            held_ext   <= new_evt.ext;
            held_code  <= new_evt.code;
         end else if (new_evt.brk && held_match) begin
            held_valid <= 1'b0;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   // ---------------- queue ----------------
   assign push_req = byte_evt & ~suppress;
   assign rd_fire  = evt_rd & ~fifo_empty;
   // the byte is consumed regardless, so a full queue loses the event
   assign drop     = push_req & fifo_full & ~rd_fire;

   kbd_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .clrn    (clrn),
      .push    (push_req),
      .wr_data (new_evt),
      .pop     (evt_rd),
      .rd_data (head_evt),
      .count   (evt_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)        overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

   // storage is not reset, so the head is masked while nothing is queued
   assign evt_valid = ~fifo_empty;
   assign evt_code  = fifo_empty ? '0 : CODE_W'(head_evt.code);
   assign evt_break = ~fifo_empty & head_evt.brk;
   assign evt_ext   = ~fifo_empty & head_evt.ext;

endmodule
